// File: rtl/fxp_add_arbiter.sv
// rtl/fxp_add_arbiter.sv - round-robin scheduler sharing one pipelined fixed-point adder among NREQ requesters
// Define FXP_ARB_SAT_EN to saturate overflowed results instead of passing the wrapped sum.
module fxp_add_arbiter #(
   parameter int WIDTH     = 16,
   parameter int FRAC_BITS = 8,
   parameter int NREQ      = 4,
   parameter int LAT       = 2,
   parameter int DEPTH     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic                    add_vld,
   output logic [WIDTH-1:0]        add_a,
   output logic [WIDTH-1:0]        add_b,
   input  logic [WIDTH-1:0]        add_sum,
   input  logic                    add_ovf,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]        rsp_sum,
   output logic                    rsp_ovf
);
   localparam int IDW = $clog2(NREQ);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + LAT + 2);

   if (NREQ < 2 || NREQ > 8 || LAT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       FRAC_BITS >= WIDTH) begin : g_bad_cfg
      $error("fxp_add_arbiter: unsupported parameter set");
   end

   logic [IDW-1:0]   last_q;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_found;
   int unsigned      cand;
   logic [IDW-1:0]   cand_idx;
   logic             credit_ok;
   logic             xfer;
   logic             wr_en;
   logic             pop;

   logic             add_vld_q;
   logic [WIDTH-1:0] add_a_q;
   logic [WIDTH-1:0] add_b_q;
   logic [IDW-1:0]   iss_id_q;
   logic [LAT-1:0]   tag_vld_q;
   logic [IDW-1:0]   tag_id_q [LAT];

   logic [CW-1:0]    inflight_q;
   logic [CW-1:0]    count_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [IDW-1:0]   mem_id_q  [DEPTH];
   logic [WIDTH-1:0] mem_sum_q [DEPTH];
   logic [DEPTH-1:0] mem_ovf_q;
   logic [WIDTH-1:0] wr_sum;

   // Every issued op owns a FIFO slot until popped, so the FIFO can never overflow.
   assign credit_ok = (inflight_q + count_q) < CW'(DEPTH);

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(last_q) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         cand_idx = cand[IDW-1:0];
         if (!gnt_found && req_valid[cand_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (gnt_found && credit_ok && !rst) req_ready[gnt_idx] = 1'b1;
   end

   assign xfer  = |req_ready;
   assign wr_en = tag_vld_q[LAT-1];
   assign pop   = rsp_valid & rsp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_vld_q <= 1'b0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         iss_id_q  <= '0;
         last_q    <= IDW'(NREQ - 1);
      end else begin
         add_vld_q <= xfer;
         if (xfer) begin
            add_a_q  <= req_a[gnt_idx*WIDTH +: WIDTH];
            add_b_q  <= req_b[gnt_idx*WIDTH +: WIDTH];
            iss_id_q <= gnt_idx;
            last_q   <= gnt_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_q <= '0;
         for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
      end else begin
         tag_vld_q[0] <= add_vld_q;
         tag_id_q[0]  <= iss_id_q;
         for (int i = 1; i < LAT; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_id_q[i]  <= tag_id_q[i-1];
         end
      end
   end

`ifdef FXP_ARB_SAT_EN
   logic [LAT-1:0] tag_sign_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_sign_q <= '0;
      end else begin
         tag_sign_q[0] <= add_a_q[WIDTH-1];
         for (int i = 1; i < LAT; i++) tag_sign_q[i] <= tag_sign_q[i-1];
      end
   end

   // On overflow both operand signs agree, so operand A's sign picks the rail.
   always_comb begin
      wr_sum = add_sum;
      if (add_ovf) wr_sum = tag_sign_q[LAT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
   end
`else
   assign wr_sum = add_sum;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_ovf_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_id_q[i]  <= '0;
            mem_sum_q[i] <= '0;
         end
      end else begin
         case ({xfer, wr_en})
            2'b10:   inflight_q <= inflight_q + CW'(1);
            2'b01:   inflight_q <= inflight_q - CW'(1);
            default: inflight_q <= inflight_q;
         endcase
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (wr_en) begin
            mem_id_q[wr_ptr_q]  <= tag_id_q[LAT-1];
            mem_sum_q[wr_ptr_q] <= wr_sum;
            mem_ovf_q[wr_ptr_q] <= add_ovf;
            wr_ptr_q            <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   assign add_vld   = add_vld_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign rsp_valid = (count_q != '0);
   assign rsp_id    = mem_id_q[rd_ptr_q];
   assign rsp_sum   = mem_sum_q[rd_ptr_q];
   assign rsp_ovf   = mem_ovf_q[rd_ptr_q];

endmodule
